product_divider: RTL
====================

# product_divider

Iterative unsigned divider that inverts the muxed 8x8 multiply datapath. It takes a 16-bit product and one of two 8-bit divisors, chosen by `sel`, and recovers the other factor as quotient plus remainder. It retires one quotient bit per cycle over a valid/ready handshake on each side, and sits downstream of the multiplier block in the datapath tests.

## Interface
Parameters:
- `DW`, 16: dividend and quotient width; the iteration count equals `DW`.
- `SW`, 8: divisor and remainder width.

Ports:
- `clk`, input, 1: the only clock; all state changes on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: request valid.
- `in_ready`, output, 1: block can accept a request.
- `dividend`, input, DW: product to divide.
- `divisorA`, input, SW: divisor used when `sel`=1.
- `divisorC`, input, SW: divisor used when `sel`=0.
- `sel`, input, 1: divisor select; sampled only at accept.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer takes the result.
- `quotient`, output, DW: quotient.
- `remainder`, output, SW: remainder.
- `div_by_zero`, output, 1: selected divisor was 0.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- `in_ready` = (state==IDLE). `out_valid` = (state==DONE).
- Accept happens on an edge where state==IDLE and `in_valid` is high.
  - Latch `dividend` and the divisor selected by `sel`.
  - Clear the partial remainder (SW+1 bits) and the iteration counter (log2(DW)+1 bits).
  - Go to BUSY.
  - If the latched divisor is 0, go to DONE instead.
- BUSY, one restoring step per edge, MSB first:
  - Shift in the next dividend bit: r = {r[SW-1:0], dividend_bit}.
  - If r >= divisor, subtract the divisor and set the quotient bit to 1. Otherwise set the quotient bit to 0.
  - The counter increments each step. After step DW-1, go to DONE.
- Width rules:
  - The partial remainder is SW+1 bits wide, so the compare never overflows.
  - The final remainder is always less than the divisor and fits in SW bits.
  - The quotient can reach 16'hFFFF, for dividend 16'hFFFF with divisor 1.
- Divide by zero:
  - `quotient`=16'hFFFF.
  - `remainder`=dividend[SW-1:0].
  - `div_by_zero`=1.
  - No BUSY cycles.
- DONE:
  - `quotient`, `remainder` and `div_by_zero` are held stable while `out_ready` is low.
  - On an edge with `out_ready` high, go to IDLE.
  - `in_ready` is low throughout DONE, so a new request is accepted no earlier than the edge after the result is taken.
- Outputs are registered and change only on edges.
- `in_valid` is ignored outside IDLE. Inputs need not be held after accept.

## Timing
- Reset values, with `rst` high at an edge taking priority over everything:
  - state=IDLE.
  - `in_ready`=1 after reset.
  - `out_valid`=0.
  - `quotient`=0, `remainder`=0, `div_by_zero`=0.
- Reset mid-operation (in BUSY or DONE) aborts the operation: no result is produced and the pending result is discarded.
- Latency, normal divisor: accept at edge E0; BUSY steps at E1..E16; `out_valid` is high in the cycle after E16.
- Latency, zero divisor: `out_valid` is high in the cycle after E0.
- Throughput: one result per DW+2 cycles when `out_ready` is tied high.
  - Accept edge, 16 BUSY edges, one DONE cycle.
  - Then IDLE for one cycle before the next accept.
- `div_by_zero` is cleared on every accept.

## Structure
- Package `divider_pkg` holds:
  - the state enum (IDLE/BUSY/DONE);
  - `DW` and `SW` defaults;
  - the quotient saturation constant `'1` used for divide by zero.
- Optional sub-module `div_step`: one combinational restoring stage.
  - Inputs: r_in[SW:0], bit_in, divisor[SW-1:0].
  - Outputs: r_out[SW:0], q_bit.
  - The top instantiates one `div_step`; the FSM, counter, handshake and registers stay in the top.

## Test plan
- 16'd40000 / divisorA=200, `sel`=1 -> `quotient`=200, `remainder`=0, `div_by_zero`=0, `out_valid` in the cycle after the 16th edge following accept.
- 16'd1000 / divisorC=7, `sel`=0, with divisorA=3 driven as a distractor -> `quotient`=142, `remainder`=6.
- 16'hFFFF / divisorA=1 -> `quotient`=16'hFFFF, `remainder`=0. Also 16'd65025 / 255 -> `quotient`=255, `remainder`=0.
- Divisor 0, dividend 16'h1234 -> `out_valid` in the cycle after the accept edge, `quotient`=16'hFFFF, `remainder`=8'h34, `div_by_zero`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE.
  - Outputs stay stable and `in_ready` stays 0.
  - A new `in_valid` pulse during DONE is ignored.
  - After `out_ready`=1, `in_ready`=1 on the next cycle.
- Assert `rst` at BUSY step 8.
  - Next cycle: IDLE, `in_ready`=1, all outputs 0.
  - A following request 100/9 returns `quotient`=11, `remainder`=1.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and defaults for the product divider: FSM states, widths and
// the quotient value reported on divide by zero.
package divider_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned SW_DEF = 8;

    localparam logic [DW_DEF-1:0] Q_SAT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division stage: shift in a dividend bit,
// conditionally subtract the divisor and emit the quotient bit.
module div_step
    import divider_pkg::*;
#(
    parameter int unsigned SW = SW_DEF
) (
    input  logic [SW:0]   r_in,
    input  logic          bit_in,
    input  logic [SW-1:0] divisor,
    output logic [SW:0]   r_out,
    output logic          q_bit
);

    logic [SW:0] r_shift;
    logic [SW:0] d_ext;

    always_comb begin
        r_shift = {r_in[SW-1:0], bit_in};
        d_ext   = {1'b0, divisor};
        q_bit   = 1'b0;
        r_out   = r_shift;
        if (r_shift >= d_ext) begin
            q_bit = 1'b1;
            r_out = r_shift - d_ext;
        end
    end

endmodule

// File: rtl/product_divider.sv
// Iterative unsigned divider: recovers a multiplier factor from a 16-bit
// product and one of two selectable divisors, one quotient bit per cycle.
module product_divider
    import divider_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned SW = SW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [SW-1:0] divisorA,
    input  logic [SW-1:0] divisorC,
    input  logic          sel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [SW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int unsigned CW = $clog2(DW) + 1;

    state_t        state;
    state_t        state_next;
    logic          accept;
    logic          last_step;
    logic          zero_div;
    logic [SW-1:0] div_sel;

    // dvd doubles as the quotient shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    logic [DW-1:0] dvd;
    logic [SW-1:0] dvs;
    logic [SW:0]   rem_r;
    logic [CW-1:0] cnt;

    logic [SW:0]   r_out;
    logic          q_bit;

    div_step #(.SW(SW)) u_step (
        .r_in    (rem_r),
        .bit_in  (dvd[DW-1]),
        .divisor (dvs),
        .r_out   (r_out),
        .q_bit   (q_bit)
    );

    // Next-state and control strobes
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        div_sel    = sel ? divisorA : divisorC;
        zero_div   = (div_sel == '0);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = zero_div ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt == CW'(DW - 1)) begin
                    last_step  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            dvd         <= '0;
            dvs         <= '0;
            rem_r       <= '0;
            cnt         <= '0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);

            if (accept) begin
                dvd         <= dividend;
                dvs         <= div_sel;
                rem_r       <= '0;
                cnt         <= '0;
                div_by_zero <= zero_div;
                if (zero_div) begin
                    quotient  <= DW'(Q_SAT);
                    remainder <= dividend[SW-1:0];
                end
            end

            if (state == BUSY) begin
                rem_r <= r_out;
                dvd   <= {dvd[DW-2:0], q_bit};
                cnt   <= cnt + CW'(1);
                if (last_step) begin
                    quotient  <= {dvd[DW-2:0], q_bit};
                    remainder <= r_out[SW-1:0];
                end
            end
        end
    end

endmodule
